fixedpoint_quantser: RTL
========================

Name: fixedpoint_quantser

Overview:
- Consumes the wide signed product from the MVU output scaler and converts it back to the array's bit-serial format.
- Selects a bit window from the scaled word and saturates to the requested precision, with optional rounding.
- Emits the result MSB-first, one bit per clock, toward the output/activation RAM write path.
- Converts wide parallel fixed-point back into narrow bit-serial operands.

Parameters:
- BWIN, 48, width of signed input word din.
- BWOUT, 16, maximum output precision in bits.
- BMSB, 6, width of msbidx field; must satisfy 2^BMSB >= BWIN.
- BPREC, 5, width of prec field; must satisfy 2^BPREC > BWOUT.

Ports:
- clk  in  1  clock.
- clr  in  1  synchronous active-high reset.
- start  in  1  request to quantize/serialize din; sampled only in IDLE.
- din  in  BWIN  signed input word.
- msbidx  in  BMSB  bit index in din that maps to the output sign bit.
- prec  in  BPREC  output precision in bits.
- busy  out  1  high while a conversion is in progress.
- dout  out  1  serial output bit, MSB-first.
- dout_valid  out  1  dout carries a valid bit.
- done  out  1  single-cycle pulse coincident with the last bit.

Behaviour:
- Clock and reset: one clock clk. clr is synchronous, active-high, and overrides everything.
- Reset values: busy=0, dout=0, dout_valid=0, done=0, FSM=IDLE. All internal registers are cleared to 0.
- FSM states: IDLE, LOAD, SHIFT.
- IDLE: when start=1, register din, msbidx and prec, then go to LOAD. When start=0, stay in IDLE.
- Operand clamping: prec=0 is treated as 1; prec>BWOUT is clamped to BWOUT; msbidx>=BWIN is clamped to BWIN-1.
- LOAD (one cycle): compute the quantized word q and load it into a BWOUT-bit shift register, left-aligned. Then go to SHIFT.
- Computing q:
  - L = msbidx - prec + 1 (signed).
  - If L >= 0: s = din >>> L (arithmetic shift).
  - If L < 0: s = din << (-L), computed at a width of at least BWIN+BWOUT with no loss.
  - Rounding term r: per the Optional Feature.
  - If s+r > 2^(prec-1)-1, then q = 2^(prec-1)-1 (positive saturation).
  - If s+r < -2^(prec-1), then q = -2^(prec-1) (negative saturation).
  - Otherwise q = s+r.
- SHIFT (exactly prec cycles): dout = current MSB of the shift register, dout_valid=1, shift left by 1 each cycle. On the prec-th bit, done=1; next state is IDLE.
- busy: high in LOAD and SHIFT, low in IDLE.
- Latency: start sampled at cycle 0 produces the first valid bit at cycle 2 and the last bit plus done at cycle 1+prec. The earliest next start is accepted at cycle 2+prec.
- start while busy: ignored; no queuing, no effect on the current conversion.
- din, msbidx and prec may change freely after the start cycle.
- clr mid-conversion: aborts immediately. The next cycle shows all outputs at reset values, and no done is produced.
- Outside SHIFT: dout=0 and dout_valid=0.

Optional Feature:
- Macro: FIXEDPOINT_QUANTSER_ROUND_EN.
- Defined: round-half-up. r = din[L-1] when L >= 1, else r = 0. Saturation is applied after adding r, so a rounding overflow saturates.
- Undefined: r = 0 (truncation toward -inf); the rounding adder is not built. All other behaviour is unchanged.

Test Plan:
- In-range pass-through: din=0x1234, msbidx=15, prec=16 -> bits 0001001000110100 on cycles 2..17; done on cycle 17; busy low on cycle 18.
- Positive saturation: din=0x10000, msbidx=7, prec=8 -> 01111111.
- Negative saturation: din=-1000, msbidx=7, prec=8 -> 10000000.
- Negative in range, rounding, zero-fill:
  - din=-3, msbidx=3, prec=4 -> 1101.
  - din=11, msbidx=4, prec=3 -> 011 with FIXEDPOINT_QUANTSER_ROUND_EN defined, 010 without.
  - din=5, msbidx=4, prec=8 (L=-3) -> 00101000.
- Boundary operands: prec=0 with din=1, msbidx=0 -> one bit "0" (value 1 saturates to 0 for 1-bit signed) and done on cycle 2.
- Control: start pulse during SHIFT -> ignored, output unchanged. clr asserted during the 3rd bit of a prec=8 conversion -> outputs zero on the next cycle, no done, FSM=IDLE. A fresh start after that produces a correct full conversion.

Source files
------------

// File: rtl/fixedpoint_quantser.sv
// fixedpoint_quantser: wide signed fixed-point to narrow bit-serial converter.
// A bit window [msbidx : msbidx-prec+1] is taken from din. The window is
// saturated to a signed prec-bit value and shifted out MSB-first, one bit
// per clock.
// Build option: define FIXEDPOINT_QUANTSER_ROUND_EN to get round-half-up
// before saturation. When it is undefined, the window is truncated toward -inf.
module fixedpoint_quantser #(
    parameter int BWIN  = 48,
    parameter int BWOUT = 16,
    parameter int BMSB  = 6,
    parameter int BPREC = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [BWIN-1:0]  din,
    input  logic [BMSB-1:0]  msbidx,
    input  logic [BPREC-1:0] prec,
    output logic             busy,
    output logic             dout,
    output logic             dout_valid,
    output logic             done
);

    // Left shifts by up to BWOUT-1 positions must not lose bits, so keep
    // BWIN+BWOUT bits plus one spare for the rounding carry.
    localparam int WX = BWIN + BWOUT + 1;
    // Signed width of the window LSB index; it ranges over -(BWOUT-1)..BWIN-1.
    localparam int LW = ((BMSB > BPREC) ? BMSB : BPREC) + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t           state_r;
    logic [BWIN-1:0]  din_r;
    logic [BMSB-1:0]  msb_r;
    logic [BPREC-1:0] prec_r;
    logic [BWOUT-1:0] shreg_r;
    logic [BPREC-1:0] cnt_r;
    logic             busy_r;
    logic             dout_r;
    logic             valid_r;
    logic             done_r;

    logic [BPREC-1:0]        prec_cl_s;
    logic [BMSB-1:0]         msb_cl_s;
    logic signed [WX-1:0]    din_x_s;
    logic signed [WX-1:0]    scaled_s;
    logic signed [WX-1:0]    sum_s;
    logic signed [WX-1:0]    pos_lim_s;
    logic signed [WX-1:0]    neg_lim_s;
    logic signed [LW-1:0]    lsb_s;
    logic [LW-1:0]           shr_amt_s;
    logic [LW-1:0]           shl_amt_s;
    logic [BWOUT-1:0]        q_s;
    logic [BWOUT-1:0]        q_aligned_s;

    // Clamp the requested operands into the legal range before they are captured.
    always_comb begin
        prec_cl_s = prec;
        msb_cl_s  = msbidx;
        if (prec == {BPREC{1'b0}}) begin
            prec_cl_s = BPREC'(1'b1);
        end else if (prec > BPREC'(BWOUT)) begin
            prec_cl_s = BPREC'(BWOUT);
        end else begin
            prec_cl_s = prec;
        end
        if ({1'b0, msbidx} >= (BMSB+1)'(BWIN)) begin
            msb_cl_s = BMSB'(BWIN - 1);
        end else begin
            msb_cl_s = msbidx;
        end
    end

    // Align the captured word so that the window LSB lands at bit 0, and derive the saturation limits.
    always_comb begin
        din_x_s   = {{(WX-BWIN){din_r[BWIN-1]}}, din_r};
        lsb_s     = $signed(LW'(msb_r)) - $signed(LW'(prec_r)) + $signed(LW'(1'b1));
        shr_amt_s = {LW{1'b0}};
        shl_amt_s = {LW{1'b0}};
        scaled_s  = din_x_s;
        if (lsb_s[LW-1]) begin
            shl_amt_s = -lsb_s;
            scaled_s  = din_x_s <<< shl_amt_s;
        end else begin
            shr_amt_s = lsb_s;
            scaled_s  = din_x_s >>> shr_amt_s;
        end
        pos_lim_s = $signed((WX'(1'b1) << (prec_r - BPREC'(1'b1))) - WX'(1'b1));
        neg_lim_s = ~pos_lim_s;
    end

`ifdef FIXEDPOINT_QUANTSER_ROUND_EN
    logic [WX-1:0] rnd_mask_s;
    logic          rnd_s;

    // Round half up: add the bit just below the window when it exists inside din.
    always_comb begin
        rnd_mask_s = {WX{1'b0}};
        rnd_s      = 1'b0;
        if (!lsb_s[LW-1] && (lsb_s != {LW{1'b0}})) begin
            rnd_mask_s = WX'(1'b1) << (shr_amt_s - LW'(1'b1));
            rnd_s      = |(din_x_s & rnd_mask_s);
        end else begin
            rnd_mask_s = {WX{1'b0}};
            rnd_s      = 1'b0;
        end
        sum_s = scaled_s + $signed({{(WX-1){1'b0}}, rnd_s});
    end
`else
    // Truncation: the shifted window is used as-is.
    always_comb begin
        sum_s = scaled_s;
    end
`endif

    // Saturate to signed prec bits and left-align the result in the shift word.
    always_comb begin
        q_s = sum_s[BWOUT-1:0];
        if (sum_s > pos_lim_s) begin
            q_s = pos_lim_s[BWOUT-1:0];
        end else if (sum_s < neg_lim_s) begin
            q_s = neg_lim_s[BWOUT-1:0];
        end else begin
            q_s = sum_s[BWOUT-1:0];
        end
        q_aligned_s = q_s << (BPREC'(BWOUT) - prec_r);
    end

    // Control FSM with registered serial outputs; clr aborts any conversion.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r <= ST_IDLE;
            din_r   <= {BWIN{1'b0}};
            msb_r   <= {BMSB{1'b0}};
            prec_r  <= {BPREC{1'b0}};
            shreg_r <= {BWOUT{1'b0}};
            cnt_r   <= {BPREC{1'b0}};
            busy_r  <= 1'b0;
            dout_r  <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    dout_r  <= 1'b0;
                    valid_r <= 1'b0;
                    done_r  <= 1'b0;
                    if (start) begin
                        din_r   <= din;
                        msb_r   <= msb_cl_s;
                        prec_r  <= prec_cl_s;
                        busy_r  <= 1'b1;
                        state_r <= ST_LOAD;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    // The first bit goes out directly, so it is visible in the first SHIFT cycle.
                    dout_r  <= q_aligned_s[BWOUT-1];
                    shreg_r <= q_aligned_s << 1;
                    cnt_r   <= prec_r - BPREC'(1'b1);
                    valid_r <= 1'b1;
                    done_r  <= (prec_r == BPREC'(1'b1));
                    busy_r  <= 1'b1;
                    state_r <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (cnt_r == {BPREC{1'b0}}) begin
                        dout_r  <= 1'b0;
                        valid_r <= 1'b0;
                        done_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        dout_r  <= shreg_r[BWOUT-1];
                        shreg_r <= shreg_r << 1;
                        cnt_r   <= cnt_r - BPREC'(1'b1);
                        valid_r <= 1'b1;
                        done_r  <= (cnt_r == BPREC'(1'b1));
                        busy_r  <= 1'b1;
                        state_r <= ST_SHIFT;
                    end
                end
                default: begin
                    dout_r  <= 1'b0;
                    valid_r <= 1'b0;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign dout       = dout_r;
    assign dout_valid = valid_r;
    assign done       = done_r;

endmodule
